riscv_hwloop_unit: RTL and testbench

Hardware-loop unit for RI5CY-class cores: it holds the start, end and count registers of `N_REGS` loops and compares the ID-stage PC against every end address. It issues the jump to the matching start address and tracks speculative (in-flight) decrements per loop. Loop counts therefore stay correct when several loop-end instructions are in the pipeline at once. It sits between the ID stage (PC, loop-setup writes), the fetch stage (jump target) and the write-back stage (decrement commit, flush).

---
 rtl/riscv_hwloop_unit_if.sv | 39 +++
 rtl/riscv_hwloop_unit.sv | 102 ++++++++++
 tb/tb_riscv_hwloop_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_hwloop_unit_if.sv
// Hardware-loop unit port bundle: ID-stage PC/setup writes, WB commits/flush, fetch redirect.
// master = pipeline side driving PC/writes/commits; slave = the loop unit.
interface riscv_hwloop_unit_if #(
  parameter int N_REGS = 2,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  localparam int RW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  logic [ADDR_W-1:0]       current_pc_i;
  logic                    pc_valid_i;
  logic [2:0]              we_i;
  logic [RW-1:0]           regid_i;
  logic [ADDR_W-1:0]       start_data_i;
  logic [ADDR_W-1:0]       end_data_i;
  logic [CNT_W-1:0]        cnt_data_i;
  logic [N_REGS-1:0]       dec_commit_i;
  logic                    flush_i;
  logic                    hwlp_jump_o;
  logic [ADDR_W-1:0]       hwlp_targ_addr_o;
  logic [N_REGS-1:0]       hwlp_sel_o;
  logic                    hwlp_stall_o;
  logic [N_REGS*CNT_W-1:0] hwlp_counter_o;
  logic [31:0]             hwlp_iter_cnt_o;

  modport master (
    output current_pc_i, pc_valid_i, we_i, regid_i, start_data_i, end_data_i,
           cnt_data_i, dec_commit_i, flush_i,
    input  hwlp_jump_o, hwlp_targ_addr_o, hwlp_sel_o, hwlp_stall_o,
           hwlp_counter_o, hwlp_iter_cnt_o
  );

  modport slave (
    input  current_pc_i, pc_valid_i, we_i, regid_i, start_data_i, end_data_i,
           cnt_data_i, dec_commit_i, flush_i,
    output hwlp_jump_o, hwlp_targ_addr_o, hwlp_sel_o, hwlp_stall_o,
           hwlp_counter_o, hwlp_iter_cnt_o
  );
endinterface

// File: rtl/riscv_hwloop_unit.sv
// Hardware-loop unit: matches ID PC against loop ends, redirects fetch, tracks speculative decrements.
// Latency: jump/target/sel/stall are combinational (zero cycle); state updates on the next edge.
// Backpressure: hwlp_stall_o holds the pipeline when the matching loop's in-flight tracker is full.
// Optional HWLP_PERF_EN builds a committed-iteration counter on hwlp_iter_cnt_o.
module riscv_hwloop_unit #(
  parameter int N_REGS       = 2,
  parameter int ADDR_W       = 32,
  parameter int CNT_W        = 32,
  parameter int MAX_INFLIGHT = 3
) (
  input logic clk,
  input logic rst,
  riscv_hwloop_unit_if.slave hw
);
  localparam int RW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic signed [CNT_W:0] EFF_MIN = (CNT_W+1)'(2);
  localparam logic [IF_W-1:0]       IF_MAX  = IF_W'(MAX_INFLIGHT);

  logic [ADDR_W-1:0]       start_q [N_REGS];
  logic [ADDR_W-1:0]       end_q   [N_REGS];
  logic [CNT_W-1:0]        cnt_q   [N_REGS];
  logic [IF_W-1:0]         infl_q  [N_REGS];
  logic signed [CNT_W:0]   eff     [N_REGS];
  logic [N_REGS-1:0]       hit;
  logic [N_REGS-1:0]       wsel;
  logic [N_REGS-1:0]       sel;
  logic                    stall;
  logic                    found;
  logic [ADDR_W-1:0]       targ;

  for (genvar g = 0; g < N_REGS; g++) begin : g_loop
    // Count net of jumps already in flight, so back-to-back loop ends see the right remainder.
    assign eff[g]  = $signed({1'b0, cnt_q[g]} - (CNT_W+1)'(infl_q[g]));
    assign hit[g]  = hw.pc_valid_i && (hw.current_pc_i == end_q[g]) && (eff[g] >= EFF_MIN);
    assign wsel[g] = (hw.regid_i == RW'(g));
    assign hw.hwlp_counter_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  // Only the highest-priority hit is considered; a full tracker stalls instead of falling through.
  always_comb begin
    sel   = '0;
    stall = 1'b0;
    found = 1'b0;
    targ  = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (hit[i] && !found) begin
        found = 1'b1;
        if (infl_q[i] < IF_MAX) begin
          sel[i] = 1'b1;
          targ   = start_q[i];
        end else begin
          stall = 1'b1;
        end
      end
    end
  end

  assign hw.hwlp_jump_o      = |sel;
  assign hw.hwlp_sel_o       = sel;
  assign hw.hwlp_targ_addr_o = targ;
  assign hw.hwlp_stall_o     = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
        infl_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (wsel[i] && hw.we_i[0]) start_q[i] <= hw.start_data_i;
        if (wsel[i] && hw.we_i[1]) end_q[i]   <= hw.end_data_i;
        if (wsel[i] && hw.we_i[2]) begin
          cnt_q[i]  <= hw.cnt_data_i;
          infl_q[i] <= '0;
        end else begin
          if (hw.dec_commit_i[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
          if (hw.flush_i)
            infl_q[i] <= '0;
          else if (sel[i] && !hw.dec_commit_i[i])
            infl_q[i] <= infl_q[i] + 1'b1;
          else if (!sel[i] && hw.dec_commit_i[i] && infl_q[i] != '0)
            infl_q[i] <= infl_q[i] - 1'b1;
        end
      end
    end
  end

`ifdef HWLP_PERF_EN
  logic [31:0] iter_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) iter_q <= '0;
    else     iter_q <= iter_q + 32'($countones(hw.dec_commit_i));
  end
  assign hw.hwlp_iter_cnt_o = iter_q;
`else
  assign hw.hwlp_iter_cnt_o = '0;
`endif
endmodule

// File: tb/tb_riscv_hwloop_unit.sv
// Directed + random bench for riscv_hwloop_unit against an integer reference model.
module tb_riscv_hwloop_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_hwloop_unit_if #(.N_REGS(2), .ADDR_W(32), .CNT_W(32)) hw ();
  riscv_hwloop_unit #(.N_REGS(2), .ADDR_W(32), .CNT_W(32), .MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst(rst), .hw(hw)
  );

  int errors = 0;
  int checks = 0;

  // Reference state
  bit [31:0] m_start [2];
  bit [31:0] m_end   [2];
  bit [31:0] m_cnt   [2];
  int        m_infl  [2];
  bit [31:0] m_iter;

  logic        last_jump, last_stall;
  logic [31:0] last_targ;
  logic [1:0]  last_sel;
  bit   [31:0] iter_before;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] exp_iter();
`ifdef HWLP_PERF_EN
    return m_iter;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_start[i] = 0; m_end[i] = 0; m_cnt[i] = 0; m_infl[i] = 0;
    end
    m_iter = 0;
  endtask

  task automatic predict(output bit jump, output bit [31:0] targ, output bit [1:0] sel, output bit stall);
    jump = 0; targ = 0; sel = 0; stall = 0;
    for (int i = 0; i < 2; i++) begin
      longint remaining = longint'(m_cnt[i]) - longint'(m_infl[i]);
      if (hw.pc_valid_i && hw.current_pc_i == m_end[i] && remaining >= 2) begin
        if (m_infl[i] < 3) begin
          jump = 1; sel[i] = 1; targ = m_start[i];
        end else begin
          stall = 1;
        end
        break;
      end
    end
  endtask

  task automatic step(input bit pcv, input bit [31:0] pc, input bit [2:0] we, input bit rid,
                      input bit [31:0] s, input bit [31:0] e, input bit [31:0] c,
                      input bit [1:0] commit, input bit fl);
    bit jump, stall;
    bit [31:0] targ;
    bit [1:0] sel;
    hw.pc_valid_i = pcv; hw.current_pc_i = pc; hw.we_i = we; hw.regid_i = rid;
    hw.start_data_i = s; hw.end_data_i = e; hw.cnt_data_i = c;
    hw.dec_commit_i = commit; hw.flush_i = fl;
    #3;
    predict(jump, targ, sel, stall);
    last_jump = hw.hwlp_jump_o; last_targ = hw.hwlp_targ_addr_o;
    last_sel = hw.hwlp_sel_o;   last_stall = hw.hwlp_stall_o;
    chk("jump", 32'(hw.hwlp_jump_o), 32'(jump));
    chk("targ", hw.hwlp_targ_addr_o, targ);
    chk("sel", 32'(hw.hwlp_sel_o), 32'(sel));
    chk("stall", 32'(hw.hwlp_stall_o), 32'(stall));
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (commit[i] && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
      if (fl) m_infl[i] = 0;
      else begin
        m_infl[i] = m_infl[i] + int'(sel[i]) - int'(commit[i]);
        if (m_infl[i] < 0) m_infl[i] = 0;
      end
      if (rid == i[0]) begin
        if (we[0]) m_start[i] = s;
        if (we[1]) m_end[i] = e;
        if (we[2]) begin m_cnt[i] = c; m_infl[i] = 0; end
      end
    end
    m_iter = m_iter + 32'(commit[0]) + 32'(commit[1]);
    #1;
    chk("cnt0", hw.hwlp_counter_o[31:0], m_cnt[0]);
    chk("cnt1", hw.hwlp_counter_o[63:32], m_cnt[1]);
    chk("iter", hw.hwlp_iter_cnt_o, exp_iter());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_jump"}, 32'(hw.hwlp_jump_o), 32'd0);
    chk({tag, "_targ"}, hw.hwlp_targ_addr_o, 32'd0);
    chk({tag, "_sel"}, 32'(hw.hwlp_sel_o), 32'd0);
    chk({tag, "_stall"}, 32'(hw.hwlp_stall_o), 32'd0);
    chk({tag, "_cnt0"}, hw.hwlp_counter_o[31:0], 32'd0);
    chk({tag, "_cnt1"}, hw.hwlp_counter_o[63:32], 32'd0);
    chk({tag, "_iter"}, hw.hwlp_iter_cnt_o, 32'd0);
  endtask

  initial begin
    hw.pc_valid_i = 0; hw.current_pc_i = 0; hw.we_i = 0; hw.regid_i = 0;
    hw.start_data_i = 0; hw.end_data_i = 0; hw.cnt_data_i = 0;
    hw.dec_commit_i = 0; hw.flush_i = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single jump on loop 0
    step(0, 0, 3'b111, 0, 32'h100, 32'h110, 3, 2'b00, 0);
    step(1, 32'h110, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("first_jump", 32'(last_jump), 32'd1);
    chk("first_targ", last_targ, 32'h100);
    chk("first_sel", 32'(last_sel), 32'd1);
    // Remaining count drops 2 -> 1: one more jump, then none
    step(1, 32'h110, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("eff2_jump", 32'(last_jump), 32'd1);
    step(1, 32'h110, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("eff1_nojump", 32'(last_jump), 32'd0);

    // Nested loops sharing an end address: loop 0 wins
    step(0, 0, 3'b110, 0, 0, 32'h200, 5, 2'b00, 0);
    step(0, 0, 3'b111, 1, 32'h300, 32'h200, 5, 2'b00, 0);
    step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("nest_sel", 32'(last_sel), 32'd1);
    chk("nest_targ", last_targ, 32'h100);

    // In-flight limit: three jumps then stall; one commit frees a slot
    step(0, 0, 3'b100, 0, 0, 0, 10, 2'b00, 0);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
      chk("limit_jump", 32'(last_jump), 32'd1);
    end
    step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("limit_stall", 32'(last_stall), 32'd1);
    chk("limit_nojump", 32'(last_jump), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    chk("limit_cnt9", hw.hwlp_counter_o[31:0], 32'd9);
    step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("limit_resume", 32'(last_jump), 32'd1);

    // Flush with a same-cycle commit
    step(0, 0, 3'b100, 0, 0, 0, 10, 2'b00, 0);
    step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    iter_before = hw.hwlp_iter_cnt_o;
    step(0, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    chk("flush_cnt", hw.hwlp_counter_o[31:0], 32'd9);
`ifdef HWLP_PERF_EN
    chk("flush_iter", hw.hwlp_iter_cnt_o - iter_before, 32'd1);
`endif
    for (int k = 0; k < 3; k++) step(1, 32'h200, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("flush_infl0_jump", 32'(last_jump), 32'd1);

    // Count write overrides a same-cycle commit and jump on loop 1
    step(0, 0, 3'b110, 1, 0, 32'h400, 4, 2'b00, 0);
    step(1, 32'h400, 0, 0, 0, 0, 0, 2'b00, 0);
    step(1, 32'h400, 3'b100, 1, 0, 0, 7, 2'b10, 0);
    chk("cntwr_jump", 32'(last_jump), 32'd1);
    chk("cntwr_cnt1", hw.hwlp_counter_o[63:32], 32'd7);

    // Asynchronous reset mid-loop
    hw.pc_valid_i = 1; hw.current_pc_i = 32'h400; hw.we_i = 0; hw.dec_commit_i = 0;
    #1;
    chk("pre_rst_jump", 32'(hw.hwlp_jump_o), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      bit [31:0] pc, s, e, c;
      bit [2:0] we;
      bit [1:0] cm;
      case ($urandom_range(0, 3))
        0: pc = m_end[0];
        1: pc = m_end[1];
        2: pc = 32'h10 * $urandom_range(0, 7);
        default: pc = $urandom;
      endcase
      we = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      s = 32'h10 * $urandom_range(0, 7);
      e = 32'h10 * $urandom_range(0, 7);
      c = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 8));
      cm = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      step($urandom_range(0, 4) != 0, pc, we, 1'($urandom), s, e, c, cm,
           $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
